// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple-dual-port synchronous RAM (one write port, one read
// port, single clock) with registered read data, a read-valid flag,
// out-of-range address detection and a post-reset hardware clear that
// zeroes every implemented word.
//
// Optional feature macro: RAM_BYPASS_EN
//   defined   - same-address read and write in one cycle returns the new data
//   undefined - same-address read and write in one cycle returns the old data
module ram_dp_clr #(
    parameter int AW    = 3,
    parameter int DW    = 4,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    rw,
    input  logic [AW-1:0] addrw,
    input  logic [AW-1:0] addrr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          addr_err,
    output logic          busy
);

    // Clear counter carries one spare bit so DEPTH = 2**AW cannot overflow it.
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CLR_LAST_L = CW'(DEPTH - 1);

    // An address is legal only below DEPTH; no modulo wrap is ever applied.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    logic [DW-1:0] mem_r [DEPTH];

    logic [0:0]    state_r;
    logic [CW-1:0] clr_cnt_r;
    logic [DW-1:0] data_out_r;
    logic          data_valid_r;
    logic          addr_err_r;
    logic          busy_r;

    logic          wr_ok_s;
    logic          rd_ok_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_wa_s;
    logic [DW-1:0] mem_wd_s;
    logic [DW-1:0] rd_data_s;

    assign wr_ok_s = addr_in_range(addrw);
    assign rd_ok_s = addr_in_range(addrr);

    // Single write port arbitration: clear sweep has priority over commands.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = '0;
        mem_wd_s = '0;
        if (reset && (state_r == ST_CLEAR)) begin
            mem_we_s = 1'b1;
            mem_wa_s = AW'(clr_cnt_r);
            mem_wd_s = '0;
        end else if (reset && (state_r == ST_READY) && rw[0] && wr_ok_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = addrw;
            mem_wd_s = data_in;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read data selection, with optional write-to-read forwarding.
    always_comb begin
        rd_data_s = mem_r[addrr];
`ifdef RAM_BYPASS_EN
        if (rw[0] && wr_ok_s && (addrw == addrr)) begin
            rd_data_s = data_in;
        end else begin
            rd_data_s = mem_r[addrr];
        end
`else
        rd_data_s = mem_r[addrr];
`endif
    end

    // Storage array; reset deliberately leaves contents alone.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Control FSM: clear sweep after reset, then command handling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    data_valid_r <= 1'b0;
                    addr_err_r   <= 1'b0;
                    clr_cnt_r    <= clr_cnt_r + CW'(1);
                    if (clr_cnt_r == CLR_LAST_L) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_READY: begin
                    busy_r     <= 1'b0;
                    addr_err_r <= (rw[0] & ~wr_ok_s) | (rw[1] & ~rd_ok_s);
                    if (rw[1]) begin
                        data_valid_r <= 1'b1;
                        data_out_r   <= rd_ok_s ? rd_data_s : '0;
                    end else begin
                        data_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_CLEAR;
                    clr_cnt_r    <= '0;
                    data_valid_r <= 1'b0;
                    addr_err_r   <= 1'b0;
                    busy_r       <= 1'b1;
                end
            endcase
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign addr_err   = addr_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: a DEPTH=8 instance for the main table and
// clear/reset sequences, and a DEPTH=6 instance for out-of-range handling.
module tb_ram_dp_clr;

`ifdef RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rw, rw6;
    logic [2:0] addrw, addrr, addrw6, addrr6;
    logic [3:0] din, din6;
    logic [3:0] dout8, dout6;
    logic       dv8, dv6, err8, err6, busy8, busy6;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] rw;
        logic [2:0] aw;
        logic [2:0] ar;
        logic [3:0] din;
        logic [3:0] dout;
        logic       dv;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ram_dp_clr #(.AW(3), .DW(4), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .rw(rw), .addrw(addrw), .addrr(addrr),
        .data_in(din), .data_out(dout8), .data_valid(dv8),
        .addr_err(err8), .busy(busy8)
    );

    ram_dp_clr #(.AW(3), .DW(4), .DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .rw(rw6), .addrw(addrw6), .addrr(addrr6),
        .data_in(din6), .data_out(dout6), .data_valid(dv6),
        .addr_err(err6), .busy(busy6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic [1:0] r, input logic [2:0] aw, input logic [2:0] ar,
                        input logic [3:0] d, input logic [3:0] eo, input logic ev);
        vec_t v;
        v.rw = r; v.aw = aw; v.ar = ar; v.din = d;
        v.dout = eo; v.dv = ev; v.err = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic cmd6(input logic [1:0] r, input logic [2:0] aw, input logic [2:0] ar,
                        input logic [3:0] d, input logic [3:0] eo, input logic ev,
                        input logic ee, input string nm);
        rw6 = r; addrw6 = aw; addrr6 = ar; din6 = d;
        tick();
        chk({nm, " dout"}, 32'(dout6), 32'(eo));
        chk({nm, " valid"}, 32'(dv6), 32'(ev));
        chk({nm, " err"}, 32'(err6), 32'(ee));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; rw = 2'b00; addrw = 3'd0; addrr = 3'd0; din = 4'd0;
        rw6 = 2'b00; addrw6 = 3'd0; addrr6 = 3'd0; din6 = 4'd0;

        // Reset held for two edges.
        tick(); tick();
        chk("rst busy8", 32'(busy8), 32'd1);
        chk("rst dout8", 32'(dout8), 32'd0);
        chk("rst valid8", 32'(dv8), 32'd0);
        chk("rst err8", 32'(err8), 32'd0);
        chk("rst busy6", 32'(busy6), 32'd1);

        // Clear sweep; commands presented meanwhile must be ignored.
        reset = 1'b1;
        rw = 2'b11; addrw = 3'd1; addrr = 3'd1; din = 4'd15;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("clr%0d busy8", k), 32'(busy8), 32'(k < 8));
            chk($sformatf("clr%0d valid8", k), 32'(dv8), 32'd0);
            chk($sformatf("clr%0d err8", k), 32'(err8), 32'd0);
            chk($sformatf("clr%0d busy6", k), 32'(busy6), 32'(k < 6));
        end
        rw = 2'b00;

        // Main vector table for the DEPTH=8 instance.
        for (int i = 0; i < 8; i++) addv(2'b10, 3'd0, 3'(i), 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) addv(2'b01, 3'(i), 3'd0, 4'(i + 1), 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) addv(2'b10, 3'd0, 3'(i), 4'd0, 4'(i + 1), 1'b1);
        addv(2'b10, 3'd0, 3'd3, 4'd0, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) addv(2'b00, 3'd0, 3'd0, 4'd0, 4'd4, 1'b0);
        addv(2'b11, 3'd0, 3'd1, 4'd12, 4'd2, 1'b1);
        addv(2'b10, 3'd0, 3'd0, 4'd0, 4'd12, 1'b1);
        addv(2'b01, 3'd3, 3'd0, 4'd9, 4'd12, 1'b0);
        addv(2'b11, 3'd3, 3'd3, 4'd5, BYP ? 4'd5 : 4'd9, 1'b1);
        addv(2'b10, 3'd0, 3'd3, 4'd0, 4'd5, 1'b1);
        addv(2'b11, 3'd7, 3'd7, 4'd6, BYP ? 4'd6 : 4'd8, 1'b1);
        addv(2'b10, 3'd0, 3'd7, 4'd0, 4'd6, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            rw = vecs[i].rw; addrw = vecs[i].aw; addrr = vecs[i].ar; din = vecs[i].din;
            tick();
            chk($sformatf("vec%0d dout", i), 32'(dout8), 32'(vecs[i].dout));
            chk($sformatf("vec%0d valid", i), 32'(dv8), 32'(vecs[i].dv));
            chk($sformatf("vec%0d err", i), 32'(err8), 32'(vecs[i].err));
        end
        rw = 2'b00;

        // Out-of-range handling on the DEPTH=6 instance.
        cmd6(2'b01, 3'd6, 3'd0, 4'd7, 4'd0, 1'b0, 1'b1, "oor wr6");
        cmd6(2'b10, 3'd0, 3'd6, 4'd0, 4'd0, 1'b1, 1'b1, "oor rd6");
        cmd6(2'b10, 3'd0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, "alias rd0");
        cmd6(2'b01, 3'd5, 3'd0, 4'd3, 4'd0, 1'b0, 1'b0, "edge wr5");
        cmd6(2'b10, 3'd0, 3'd5, 4'd0, 4'd3, 1'b1, 1'b0, "edge rd5");
        cmd6(2'b11, 3'd7, 3'd2, 4'd9, 4'd0, 1'b1, 1'b1, "both wr7");
        cmd6(2'b00, 3'd0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, "err drop");
        cmd6(2'b11, 3'd2, 3'd6, 4'd9, 4'd0, 1'b1, 1'b1, "both rd6");

        // Reset while ready with a read pending in the same cycle.
        reset = 1'b0; rw = 2'b10; addrr = 3'd0;
        tick();
        chk("rrst valid8", 32'(dv8), 32'd0);
        chk("rrst busy8", 32'(busy8), 32'd1);
        chk("rrst dout8", 32'(dout8), 32'd0);

        // Three clear cycles, then reset again during the fourth.
        reset = 1'b1; rw = 2'b01; addrw = 3'd0; din = 4'd10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("mid%0d busy8", k), 32'(busy8), 32'd1);
        end
        reset = 1'b0;
        tick();
        chk("mid rst busy8", 32'(busy8), 32'd1);
        reset = 1'b1; rw = 2'b11; addrr = 3'd3;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("reclr%0d busy8", k), 32'(busy8), 32'(k < 8));
            chk($sformatf("reclr%0d valid8", k), 32'(dv8), 32'd0);
        end

        // Everything reads back as zero: no stray writes survived.
        rw = 2'b10;
        addrr = 3'd0; tick();
        chk("post rd0 dout", 32'(dout8), 32'd0);
        chk("post rd0 valid", 32'(dv8), 32'd1);
        addrr = 3'd3; tick();
        chk("post rd3 dout", 32'(dout8), 32'd0);
        addrr = 3'd7; tick();
        chk("post rd7 dout", 32'(dout8), 32'd0);
        rw = 2'b00; tick();
        chk("post idle valid", 32'(dv8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
